// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encoding, byte-lane masks and request-decode helpers.
// Optional build macro: LSU_MISALIGN_TRAP_EN (the misaligned() helper is only
// referenced when it is defined).
package lsu_pkg;

  // RV32I load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LD     = 3'd1;
  localparam logic [2:0] ST_ST_W   = 3'd2;
  localparam logic [2:0] ST_RMW_RD = 3'd3;
  localparam logic [2:0] ST_RMW_WR = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LD     = ST_LD,
    ST_W   = ST_ST_W,
    RMW_RD = ST_RMW_RD,
    RMW_WR = ST_RMW_WR,
    RESP   = ST_RESP
  } state_t;

  // Byte-lane masks for one byte and one halfword, right-aligned
  localparam logic [31:0] LANE_B = 32'h0000_00FF;
  localparam logic [31:0] LANE_H = 32'h0000_FFFF;

  // funct3 values with no RV32I meaning for the given direction
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 > F3_SW);
    else
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Access not naturally aligned for its size (byte accesses never are)
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Combinational data formatter. With is_store = 0 it extracts the addressed
// byte/halfword/word of 'word' and sign- or zero-extends it; with is_store = 1
// it returns 'word' with the addressed byte or halfword lane replaced by the
// low bits of 'wdata'. Sub-word offsets are forced to natural alignment here,
// so callers that trap misalignment simply never present such an access.
module lsu_fmt
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] dout
);

  logic [1:0]  eff_off;
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane;
  logic [31:0] merged;
  logic [31:0] loaded;
  logic        sext;

  // Lane selection, load extraction and store merge
  always_comb begin
    eff_off = 2'b00;
    case (funct3[1:0])
      2'b00:   eff_off = offset;
      2'b01:   eff_off = {offset[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
    shamt   = {eff_off, 3'b000};
    shifted = word >> shamt;
    lane    = funct3[0] ? LANE_H : LANE_B;
    merged  = (word & ~(lane << shamt)) | ((wdata & lane) << shamt);
    sext    = ~funct3[2];
    loaded  = word;
    case (funct3[1:0])
      2'b00:   loaded = {{24{sext & shifted[7]}},  shifted[7:0]};
      2'b01:   loaded = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: loaded = word;
    endcase
    dout = is_store ? merged : loaded;
  end

endmodule

// File: rtl/lsu_dm_if.sv
// Load/store unit between the RV32I execute stage and a word-only data memory.
// One request at a time; sub-word stores use a registered read-modify-write.
//
// Handshake: a request is taken at a rising edge where req_valid & req_ready;
// req_ready is high exactly in IDLE. The response is a single-cycle rsp_valid
// pulse (rsp_rdata/rsp_err qualified by it) with no back-pressure.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN. When defined, misaligned
// halfword/word accesses return rsp_err without touching memory; otherwise the
// low address bits are masked to natural alignment.
//
// dbg_state exposes the FSM state for checkers.
module lsu_dm_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [XLEN-1:0]   dm_wd,
  input  logic [XLEN-1:0]   dm_rd,
  output logic [2:0]        dbg_state
);

  state_t            state;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [XLEN-1:0]   wdata_q;

  logic [ADDR_W-1:0] req_idx;
  logic              req_err;
  logic [XLEN-1:0]   ld_word;
  logic [XLEN-1:0]   merge_word;
  logic              unused_addr_bits;

  // Word index wraps modulo the memory depth; upper address bits are ignored
  assign req_idx          = req_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^req_addr[XLEN-1:ADDR_W+2];

  assign req_ready = (state == IDLE);
  assign dbg_state = state;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = f3_illegal(req_we, req_funct3) | misaligned(req_funct3, req_addr[1:0]);
`else
  assign req_err = f3_illegal(req_we, req_funct3);
`endif

  // Load path: extract and extend the addressed lane of the read word
  lsu_fmt u_fmt_load (
    .is_store (1'b0),
    .funct3   (f3_q),
    .offset   (off_q),
    .word     (dm_rd),
    .wdata    (wdata_q),
    .dout     (ld_word)
  );

  // Store path: merge store data into the read word for SB/SH
  lsu_fmt u_fmt_merge (
    .is_store (1'b1),
    .funct3   (f3_q),
    .offset   (off_q),
    .word     (dm_rd),
    .wdata    (wdata_q),
    .dout     (merge_word)
  );

  // Request FSM with registered memory-side and response-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      f3_q      <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            f3_q    <= req_funct3;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            dm_addr <= req_idx;
            if (req_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (!req_we) begin
              state <= LD;
            end else if (req_funct3 == F3_SW) begin
              state <= ST_W;
              dm_we <= 1'b1;
              dm_wd <= req_wdata;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LD: begin
          rsp_rdata <= ld_word;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        ST_W: begin
          dm_we     <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RMW_RD: begin
          dm_wd <= merge_word;
          dm_we <= 1'b1;
          state <= RMW_WR;
        end
        RMW_WR: begin
          dm_we     <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          dm_addr   <= '0;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          dm_we     <= 1'b0;
          dm_addr   <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
